// File: rtl/jt51_wrseq_defs.sv
// Shared definitions for the jt51 write sequencer.
// State encoding, busy bit index and counter sizing helper.
package jt51_wrseq_defs;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WA,
    ST_GA,
    ST_BA,
    ST_WD,
    ST_GD,
    ST_BD
  } state_t;

  localparam int BUSY_BIT = 7;

  // Bits needed to hold values 0..n.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/jt51_wrseq_fifo.sv
// Synchronous 16-bit FIFO with occupancy and overflow detect.
// Pointers carry one extra wrap bit to tell full from empty.
module jt51_wrseq_fifo #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [15:0]   i_wdata,
  input  logic          i_pop,
  output logic [15:0]   o_rdata,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_level,
  output logic          o_ovf
);

  logic [15:0] r_mem [2**AW];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic        w_wr;
  logic        w_rd;

  assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_empty = (r_wptr == r_rptr);
  assign o_level = r_wptr - r_rptr;
  assign o_rdata = r_mem[r_rptr[AW-1:0]];

  // Full is judged before any same-cycle pop.
  assign w_wr  = i_push && !o_full;
  assign w_rd  = i_pop && !o_empty;
  assign o_ovf = i_push && o_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/jt51_wrseq.sv
// Host-side write sequencer: queues (addr,data) pairs and replays
// them to jt51 as two strobed writes, waiting on the busy flag.
module jt51_wrseq
  import jt51_wrseq_defs::*;
#(
  parameter int AW    = 4,
  parameter int GUARD = 3,
  parameter int TMO   = 1023
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    push_addr,
  input  logic [7:0]    push_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          ovf,
  input  logic          clr_err,
  output logic          tmo,
  output logic          idle,
  output logic          ym_cs_n,
  output logic          ym_wr_n,
  output logic          ym_a0,
  output logic [7:0]    ym_din,
  input  logic [7:0]    ym_dout
);

  localparam int GW = cnt_w(GUARD);
  localparam int WW = cnt_w(TMO);
  localparam logic [GW-1:0] G_LAST = GW'(GUARD - 1);
  localparam logic [WW-1:0] T_LAST = WW'((TMO > 0) ? TMO - 1 : 0);

  state_t      r_st;
  state_t      w_nx;
  logic [GW-1:0] r_gcnt;
  logic [WW-1:0] r_wcnt;
  logic [7:0]  r_cur;
  logic [7:0]  r_din;
  logic        r_csn;
  logic        r_a0;
  logic        r_ovf;
  logic        r_tmo;
  logic [15:0] w_head;
  logic        w_pop;
  logic        w_fovf;
  logic        w_busy;
  logic        w_wait;
  logic        w_guard;
  logic        w_hit;
  logic        w_go;
  logic        w_unused;

  jt51_wrseq_fifo #(.AW(AW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (push),
    .i_wdata ({push_addr, push_data}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (full),
    .o_empty (empty),
    .o_level (level),
    .o_ovf   (w_fovf)
  );

  assign w_busy  = ym_dout[BUSY_BIT];
  assign w_unused = ^ym_dout[6:0];
  assign w_pop   = (r_st == ST_LOAD);
  assign w_wait  = (r_st == ST_BA) || (r_st == ST_BD);
  assign w_guard = (r_st == ST_GA) || (r_st == ST_GD);
  assign w_hit   = (TMO != 0) && w_wait && w_busy &&
                   (r_wcnt == T_LAST);
  assign w_go    = !w_busy || w_hit;

  always_comb begin
    w_nx = r_st;
    unique case (r_st)
      ST_IDLE: if (!empty) w_nx = ST_LOAD;
      ST_LOAD: w_nx = ST_WA;
      ST_WA:   w_nx = ST_GA;
      ST_GA:   if (r_gcnt == G_LAST) w_nx = ST_BA;
      ST_BA:   if (w_go) w_nx = ST_WD;
      ST_WD:   w_nx = ST_GD;
      ST_GD:   if (r_gcnt == G_LAST) w_nx = ST_BD;
      ST_BD:   if (w_go) w_nx = empty ? ST_IDLE : ST_LOAD;
      default: w_nx = ST_IDLE;
    endcase
  end

  // Pin values are derived from the next state so they are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st   <= ST_IDLE;
      r_gcnt <= '0;
      r_wcnt <= '0;
      r_cur  <= '0;
      r_din  <= '0;
      r_csn  <= 1'b1;
      r_a0   <= 1'b0;
    end else begin
      r_st  <= w_nx;
      r_csn <= !((w_nx == ST_WA) || (w_nx == ST_WD));
      if (r_st == ST_LOAD) r_cur <= w_head[7:0];
      if (w_nx == ST_WA) begin
        r_a0  <= 1'b0;
        r_din <= w_head[15:8];
      end
      if (w_nx == ST_WD) begin
        r_a0  <= 1'b1;
        r_din <= r_cur;
      end
      if (w_guard)
        r_gcnt <= (r_gcnt == G_LAST) ? '0 : r_gcnt + 1'b1;
      else
        r_gcnt <= '0;
      if (w_wait)
        r_wcnt <= w_go ? '0 : r_wcnt + 1'b1;
      else
        r_wcnt <= '0;
    end
  end

  // A new error event wins over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_tmo <= 1'b0;
    end else begin
      if (w_fovf) r_ovf <= 1'b1;
      else if (clr_err) r_ovf <= 1'b0;
      if (w_hit) r_tmo <= 1'b1;
      else if (clr_err) r_tmo <= 1'b0;
    end
  end

  assign ovf     = r_ovf;
  assign tmo     = r_tmo;
  assign idle    = empty && (r_st == ST_IDLE);
  assign ym_cs_n = r_csn;
  assign ym_wr_n = r_csn;
  assign ym_a0   = r_a0;
  assign ym_din  = r_din;

endmodule
